// File: rtl/exhaustive_vector_sequencer_if.sv
// Record stream from the vector sequencer to the downstream logger.
// One {vector, response} record per applied vector, valid/ready handshake.
interface exhaustive_vector_sequencer_if #(
    parameter int unsigned WIDTH = 6
);
    logic             rec_valid;
    logic             rec_ready;
    logic [0:WIDTH-1] rec_vector;
    logic             rec_bit;

    modport master (output rec_valid, output rec_vector, output rec_bit, input rec_ready);
    modport slave  (input rec_valid, input rec_vector, input rec_bit, output rec_ready);
endinterface

// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps every input vector of a combinational target, samples its response after a
// programmable settle time, compacts the responses into a MISR and streams one record per vector.
module exhaustive_vector_sequencer #(
    parameter int unsigned       WIDTH  = 6,
    parameter int unsigned       SETTLE = 1,
    parameter int unsigned       SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
    input  logic                         CK,
    input  logic                         reset,
    input  logic                         start,
    output logic [0:WIDTH-1]             N,
    input  logic                         resp_in,
    exhaustive_vector_sequencer_if.master rec,
    output logic [SIG_W-1:0]             signature,
    output logic [WIDTH:0]               ones_count,
    output logic                         busy,
    output logic                         done
);
    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [0:WIDTH-1] n_q, n_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [0:WIDTH-1] rvec_q, rvec_d;
    logic             rbit_q, rbit_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [WIDTH:0]   ones_q, ones_d;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            rvec_q  <= '0;
            rbit_q  <= 1'b0;
            sig_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            rvec_q  <= rvec_d;
            rbit_q  <= rbit_d;
            sig_q   <= sig_d;
            ones_q  <= ones_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        rvec_d  = rvec_q;
        rbit_d  = rbit_q;
        sig_d   = sig_q;
        ones_d  = ones_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_d     = '0;
                    sig_d   = '0;
                    ones_d  = '0;
                    cnt_d   = SETTLE_C;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    rbit_d  = resp_in;
                    rvec_d  = n_q;
                    // Shift left, fold the polynomial in on MSB carry-out, inject the response at bit 0.
                    sig_d   = {sig_q[SIG_W-2:0], 1'b0}
                            ^ (sig_q[SIG_W-1] ? POLY : '0)
                            ^ {{(SIG_W-1){1'b0}}, resp_in};
                    ones_d  = ones_q + (WIDTH+1)'(resp_in);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rec.rec_ready) begin
                    if (&n_q) begin
                        state_d = ST_DONE;
                    end else begin
                        n_d     = n_q + WIDTH'(1);
                        cnt_d   = SETTLE_C;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign N              = n_q;
    assign rec.rec_valid  = (state_q == ST_EMIT);
    assign rec.rec_vector = rvec_q;
    assign rec.rec_bit    = rbit_q;
    assign signature      = sig_q;
    assign ones_count     = ones_q;
    assign busy           = (state_q == ST_WAIT) || (state_q == ST_EMIT);
    assign done           = (state_q == ST_DONE);
endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Directed bench for exhaustive_vector_sequencer: scoreboarded record stream, MISR/ones model,
// backpressure, asynchronous reset mid-sweep and a SETTLE=3 instance with a registered target.
module tb_exhaustive_vector_sequencer;
    localparam int unsigned W = 6;

    logic CK = 1'b0;
    logic reset = 1'b1;
    always #5 CK = ~CK;

    logic start = 1'b0;
    logic which = 1'b0;
    logic rdy   = 1'b1;
    int   mode  = 0;

    logic [0:W-1] N1, N3;
    logic         resp1, resp3;
    logic [15:0]  sig1, sig3;
    logic [W:0]   ones1, ones3;
    logic         busy1, busy3, done1, done3;
    logic         p1, p2, p3;

    exhaustive_vector_sequencer_if #(.WIDTH(W)) if1 ();
    exhaustive_vector_sequencer_if #(.WIDTH(W)) if3 ();

    assign if1.rec_ready = which ? 1'b1 : rdy;
    assign if3.rec_ready = which ? rdy : 1'b1;

    assign resp1 = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (mode == 2) ? &N1 : ^N1;

    always @(posedge CK) begin
        p1 <= ^N3;
        p2 <= p1;
        p3 <= p2;
    end
    assign resp3 = p3;

    exhaustive_vector_sequencer #(.WIDTH(W)) dut (
        .CK(CK), .reset(reset), .start(start && !which), .N(N1), .resp_in(resp1),
        .rec(if1.master), .signature(sig1), .ones_count(ones1), .busy(busy1), .done(done1)
    );

    exhaustive_vector_sequencer #(.WIDTH(W), .SETTLE(3)) dut3 (
        .CK(CK), .reset(reset), .start(start && which), .N(N3), .resp_in(resp3),
        .rec(if3.master), .signature(sig3), .ones_count(ones3), .busy(busy3), .done(done3)
    );

    logic         o_valid, o_bit, o_busy, o_done;
    logic [0:W-1] o_vec, o_N;
    logic [15:0]  o_sig;
    logic [W:0]   o_ones;
    assign o_valid = which ? if3.rec_valid  : if1.rec_valid;
    assign o_vec   = which ? if3.rec_vector : if1.rec_vector;
    assign o_bit   = which ? if3.rec_bit    : if1.rec_bit;
    assign o_N     = which ? N3    : N1;
    assign o_sig   = which ? sig3  : sig1;
    assign o_ones  = which ? ones3 : ones1;
    assign o_busy  = which ? busy3 : busy1;
    assign o_done  = which ? done3 : done1;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W:0] q[$];
    int    ones_recs;
    string last_line;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic exp_resp(input int m, input logic [W-1:0] v);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return &v;
            default: return ^v;
        endcase
    endfunction

    function automatic logic [15:0] exp_sig(input int m);
        logic [15:0] s = 16'h0000;
        logic        msb;
        for (int v = 0; v < (1 << W); v++) begin
            logic [W-1:0] vv = v[W-1:0];
            msb = s[15];
            s = s << 1;
            if (msb) s = s ^ 16'h1021;
            s[0] = s[0] ^ exp_resp(m, vv);
        end
        return s;
    endfunction

    task automatic sweep(input bit bp, input int pulse_at, output int cyc);
        logic [0:W-1] pv;
        logic         pb;
        bit           stalled;
        logic [W:0]   e;
        cyc = 0;
        stalled = 0;
        pv = '0;
        pb = 1'b0;
        ones_recs = 0;
        last_line = "";
        q.delete();
        for (int v = 0; v < (1 << W); v++) begin
            logic [W-1:0] vv = v[W-1:0];
            q.push_back({vv, exp_resp(mode, vv)});
        end
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
        forever begin
            @(negedge CK);
            if (o_done || cyc > 4000) break;
            if (o_valid) begin
                if (stalled) begin
                    chk("stall_vector", 64'(o_vec), 64'(pv));
                    chk("stall_bit", 64'(o_bit), 64'(pb));
                end
                rdy = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
                if (rdy) begin
                    chk("record_expected", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("record", 64'({o_vec, o_bit}), 64'(e));
                    end
                    if (o_bit) begin
                        ones_recs++;
                        last_line = $sformatf("%b %b", o_vec, o_bit);
                    end
                end
                stalled = !rdy;
                pv = o_vec;
                pb = o_bit;
            end else begin
                stalled = 0;
            end
            start = (cyc == pulse_at);
            @(posedge CK);
            cyc++;
        end
        start = 1'b0;
        rdy = 1'b1;
        chk("sweep_done", 64'(o_done), 64'd1);
        chk("records_left", 64'(q.size()), 64'd0);
        chk("busy_at_done", 64'(o_busy), 64'd0);
        chk("N_at_done", 64'(o_N), 64'h3f);
    endtask

    initial begin
        int  cyc;
        bit  hit;

        #1 reset = 1'b0;
        #1;
        chk("rst_N", 64'(N1), 64'd0);
        chk("rst_valid", 64'(if1.rec_valid), 64'd0);
        chk("rst_sig", 64'(sig1), 64'd0);
        chk("rst_ones", 64'(ones1), 64'd0);
        chk("rst_busy_done", 64'({busy1, done1}), 64'd0);
        repeat (3) @(negedge CK);
        reset = 1'b1;

        mode = 0;
        sweep(0, -1, cyc);
        chk("zero_cycles", 64'(cyc), 64'd192);
        chk("zero_sig", 64'(sig1), 64'h0000);
        chk("zero_ones", 64'(ones1), 64'd0);

        mode = 1;
        sweep(0, 50, cyc);
        chk("one_cycles", 64'(cyc), 64'd192);
        chk("one_ones", 64'(ones1), 64'd64);
        chk("one_sig", 64'(sig1), 64'(exp_sig(1)));
        chk("one_bits", 64'(ones_recs), 64'd64);

        mode = 2;
        sweep(0, -1, cyc);
        chk("and_ones", 64'(ones1), 64'd1);
        chk("and_recs", 64'(ones_recs), 64'd1);
        chk("and_line", 64'(last_line == "111111 1"), 64'd1);
        chk("and_sig", 64'(sig1), 64'(exp_sig(2)));

        mode = 3;
        sweep(1, -1, cyc);
        chk("bp_ones", 64'(ones1), 64'd32);
        chk("bp_sig", 64'(sig1), 64'(exp_sig(3)));

        mode = 1;
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge CK);
            if (o_valid && o_vec == 6'b010110) hit = 1;
        end
        chk("reach_010110", 64'(hit), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_N", 64'(N1), 64'd0);
        chk("arst_rec", 64'({if1.rec_valid, if1.rec_vector, if1.rec_bit}), 64'd0);
        chk("arst_sig", 64'(sig1), 64'd0);
        chk("arst_ones", 64'(ones1), 64'd0);
        chk("arst_busy_done", 64'({busy1, done1}), 64'd0);
        @(negedge CK);
        reset = 1'b1;
        repeat (3) @(negedge CK);
        chk("idle_after_rst", 64'({busy1, done1, if1.rec_valid}), 64'd0);
        sweep(0, -1, cyc);
        chk("restart_cycles", 64'(cyc), 64'd192);
        chk("restart_ones", 64'(ones1), 64'd64);

        which = 1'b1;
        mode = 3;
        sweep(0, 100, cyc);
        chk("settle3_cycles", 64'(cyc), 64'd320);
        chk("settle3_ones", 64'(ones3), 64'd32);
        chk("settle3_sig", 64'(sig3), 64'(exp_sig(3)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
